// File: rtl/mem_arbiter_if.sv
// Shared memory-side types and the request/response bundle for mem_arbiter.
// The arbiter connects through the slave modport; the cache/memory side
// (or a testbench) drives the bundle through the master modport.
package mem_arbiter_pkg;

  typedef logic [31:0] ADDR;
  typedef logic [63:0] MEM_BLOCK;
  typedef logic [3:0]  MEM_TAG;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'h0,
    MEM_LOAD  = 2'h1,
    MEM_STORE = 2'h2
  } MEM_COMMAND;

  // Block request: valid flag plus the 13-bit block tag.
  typedef struct packed {
    logic        valid;
    logic [12:0] tag;
  } I_ADDR_PACKET;

endpackage

interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  I_ADDR_PACKET icache_req_addr;
  logic         icache_req_accepted;
  I_ADDR_PACKET dcache_req_addr;
  logic         dcache_req_accepted;
  logic         dcache_wb_valid;
  I_ADDR_PACKET dcache_wb_addr;
  MEM_BLOCK     dcache_wb_data;
  logic         wb_almost_full;
  logic         wb_overflow;
  MEM_TAG       current_req_tag;
  MEM_COMMAND   proc2mem_command;
  ADDR          proc2mem_addr;
  MEM_BLOCK     proc2mem_data;
  MEM_TAG       mem2proc_transaction_tag;

  modport slave (
    input  icache_req_addr, dcache_req_addr, dcache_wb_valid, dcache_wb_addr,
           dcache_wb_data, mem2proc_transaction_tag,
    output icache_req_accepted, dcache_req_accepted, wb_almost_full, wb_overflow,
           current_req_tag, proc2mem_command, proc2mem_addr, proc2mem_data
  );

  modport master (
    output icache_req_addr, dcache_req_addr, dcache_wb_valid, dcache_wb_addr,
           dcache_wb_data, mem2proc_transaction_tag,
    input  icache_req_accepted, dcache_req_accepted, wb_almost_full, wb_overflow,
           current_req_tag, proc2mem_command, proc2mem_addr, proc2mem_data
  );

endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single memory port between icache fills, dcache
// miss reads and dcache dirty writebacks. Writebacks are one-cycle pulses,
// so they are buffered in an in-order FIFO and drained when the port is free.
// A read whose block is still waiting in the FIFO (or being pushed this
// cycle) is held until that writeback has gone out, so memory never returns
// stale data.
// Optional feature: define MEM_ARB_STARVE_GUARD_EN to add the icache
// starvation counter, which promotes icache after STARVE_LIMIT denied cycles.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int WB_DEPTH     = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clock,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam int IW = $clog2(WB_DEPTH);
  localparam int CW = IW + 1;

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_WB,
    GRANT_ICACHE,
    GRANT_DCACHE
  } grant_t;

  logic [12:0]   wb_tag_q  [WB_DEPTH];
  logic [12:0]   wb_tag_d  [WB_DEPTH];
  MEM_BLOCK      wb_data_q [WB_DEPTH];
  MEM_BLOCK      wb_data_d [WB_DEPTH];
  logic [CW-1:0] head_q, head_d;
  logic [CW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          wb_overflow_q, wb_overflow_d;

  logic [WB_DEPTH-1:0] occupied;
  logic          ic_hit, dc_hit;
  logic          ic_hold, dc_hold;
  logic          ic_ready, dc_ready;
  logic          fifo_empty, fifo_full, fifo_urgent;
  logic          tag_ok, pop, push_ok;
  logic          icache_accept, dcache_accept;
  logic          starve_promote;
  grant_t        grant;
  logic [IW-1:0] head_idx, tail_idx;

  // The writeback packet carries its own valid bit, which duplicates
  // dcache_wb_valid; only the tag is meaningful here.
  logic unused_wb_addr_valid;
  assign unused_wb_addr_valid = bus.dcache_wb_addr.valid;

  assign head_idx    = head_q[IW-1:0];
  assign tail_idx    = tail_q[IW-1:0];
  assign fifo_empty  = (count_q == '0);
  assign fifo_full   = (count_q == CW'(WB_DEPTH));
  assign tag_ok      = (bus.mem2proc_transaction_tag != '0);

  function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] p);
    return (p == CW'(WB_DEPTH - 1)) ? '0 : p + CW'(1);
  endfunction

  // Tag-compare both read requests against every live FIFO entry plus the writeback arriving this cycle.
  always_comb begin
    logic [IW-1:0] off;
    occupied = '0;
    ic_hit   = 1'b0;
    dc_hit   = 1'b0;
    off      = '0;
    for (int i = 0; i < WB_DEPTH; i++) begin
      off         = IW'(i) - head_idx;
      occupied[i] = ({1'b0, off} < count_q);
      if (occupied[i] && (wb_tag_q[i] == bus.icache_req_addr.tag)) ic_hit = 1'b1;
      if (occupied[i] && (wb_tag_q[i] == bus.dcache_req_addr.tag)) dc_hit = 1'b1;
    end
    if (bus.dcache_wb_valid && (bus.dcache_wb_addr.tag == bus.icache_req_addr.tag)) ic_hit = 1'b1;
    if (bus.dcache_wb_valid && (bus.dcache_wb_addr.tag == bus.dcache_req_addr.tag)) dc_hit = 1'b1;
  end

  assign ic_hold     = bus.icache_req_addr.valid && ic_hit;
  assign dc_hold     = bus.dcache_req_addr.valid && dc_hit;
  assign ic_ready    = bus.icache_req_addr.valid && !ic_hit;
  assign dc_ready    = bus.dcache_req_addr.valid && !dc_hit;
  assign fifo_urgent = !fifo_empty &&
                       ((count_q >= CW'(WB_DEPTH - 1)) || dc_hold || ic_hold);

`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_q, starve_d;

  // Count consecutive cycles icache asked and was not accepted, saturating at the limit.
  always_comb begin
    starve_d = '0;
    if (bus.icache_req_addr.valid && !icache_accept) begin
      starve_d = (starve_q == SW'(STARVE_LIMIT)) ? starve_q : starve_q + SW'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clock) begin
    if (reset) starve_q <= '0;
    else       starve_q <= starve_d;
  end

  assign starve_promote = (starve_q == SW'(STARVE_LIMIT));
`else
  logic unused_starve_cfg;
  assign unused_starve_cfg = (STARVE_LIMIT > 0);
  assign starve_promote    = 1'b0;
`endif

  // Pick exactly one winner per cycle; nothing is granted while reset is held.
  always_comb begin
    grant = GRANT_NONE;
    if (fifo_urgent)                    grant = GRANT_WB;
    else if (starve_promote && ic_ready) grant = GRANT_ICACHE;
    else if (dc_ready)                  grant = GRANT_DCACHE;
    else if (ic_ready)                  grant = GRANT_ICACHE;
    else if (!fifo_empty)               grant = GRANT_WB;
    if (reset) grant = GRANT_NONE;
  end

  assign icache_accept = (grant == GRANT_ICACHE) && tag_ok;
  assign dcache_accept = (grant == GRANT_DCACHE) && tag_ok;
  assign pop           = (grant == GRANT_WB) && tag_ok;
  assign push_ok       = bus.dcache_wb_valid && (!fifo_full || pop);

  // Drive the memory port from the winner; data stays zero unless storing.
  always_comb begin
    bus.proc2mem_command = MEM_NONE;
    bus.proc2mem_addr    = '0;
    bus.proc2mem_data    = '0;
    unique case (grant)
      GRANT_WB: begin
        bus.proc2mem_command = MEM_STORE;
        bus.proc2mem_addr    = {16'b0, wb_tag_q[head_idx], 3'b0};
        bus.proc2mem_data    = wb_data_q[head_idx];
      end
      GRANT_ICACHE: begin
        bus.proc2mem_command = MEM_LOAD;
        bus.proc2mem_addr    = {16'b0, bus.icache_req_addr.tag, 3'b0};
      end
      GRANT_DCACHE: begin
        bus.proc2mem_command = MEM_LOAD;
        bus.proc2mem_addr    = {16'b0, bus.dcache_req_addr.tag, 3'b0};
      end
      default: begin
      end
    endcase
  end

  assign bus.icache_req_accepted = icache_accept;
  assign bus.dcache_req_accepted = dcache_accept;
  assign bus.current_req_tag     = bus.mem2proc_transaction_tag;
  assign bus.wb_almost_full      = !reset && (count_q >= CW'(WB_DEPTH - 1));
  assign bus.wb_overflow         = !reset && wb_overflow_q;

  // FIFO bookkeeping: a pop in the same cycle frees the slot a full-FIFO push needs.
  always_comb begin
    wb_tag_d      = wb_tag_q;
    wb_data_d     = wb_data_q;
    head_d        = head_q;
    tail_d        = tail_q;
    wb_overflow_d = wb_overflow_q;
    if (push_ok) begin
      wb_tag_d[tail_idx]  = bus.dcache_wb_addr.tag;
      wb_data_d[tail_idx] = bus.dcache_wb_data;
      tail_d              = wrap_inc(tail_q);
    end
    if (pop) head_d = wrap_inc(head_q);
    if (bus.dcache_wb_valid && fifo_full && !pop) wb_overflow_d = 1'b1;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO control registers; reset discards any pending writebacks.
  always_ff @(posedge clock) begin
    if (reset) begin
      head_q        <= '0;
      tail_q        <= '0;
      count_q       <= '0;
      wb_overflow_q <= 1'b0;
    end else begin
      head_q        <= head_d;
      tail_q        <= tail_d;
      count_q       <= count_d;
      wb_overflow_q <= wb_overflow_d;
    end
  end

  // FIFO storage; contents are only meaningful inside the head/count window.
  always_ff @(posedge clock) begin
    wb_tag_q  <= wb_tag_d;
    wb_data_q <= wb_data_d;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a table of directed vectors, a few
// multi-cycle sequences (retry, starvation, overflow, full push+pop), then
// randomized traffic compared against a queue-based reference model.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int WB_DEPTH     = 4;
  localparam int STARVE_LIMIT = 8;
`ifdef MEM_ARB_STARVE_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif

  logic clock;
  logic reset;
  mem_arbiter_if bus ();

  mem_arbiter #(.WB_DEPTH(WB_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int assertions = 0;
  int failures   = 0;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [12:0] it;
    logic        dv;
    logic [12:0] dt;
    logic        wv;
    logic [12:0] wt;
    logic [63:0] wd;
    logic [3:0]  mt;
    logic [1:0]  e_cmd;
    logic [31:0] e_addr;
    logic [63:0] e_data;
    logic        e_iacc;
    logic        e_dacc;
    logic        e_af;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[$];

  typedef struct {
    logic [12:0] tag;
    logic [63:0] data;
  } wb_entry_t;

  wb_entry_t m_q[$];
  int        m_starve = 0;
  bit        m_ovf    = 1'b0;
  int        m_grant  = 0;
  logic [1:0]  e_cmd;
  logic [31:0] e_addr;
  logic [63:0] e_data;
  logic        e_iacc, e_dacc, e_af, e_ovf;

  task automatic applyStimulus(input logic rst, input logic iv, input logic [12:0] it,
                               input logic dv, input logic [12:0] dt, input logic wv,
                               input logic [12:0] wt, input logic [63:0] wd, input logic [3:0] mt);
    reset                        = rst;
    bus.icache_req_addr.valid    = iv;
    bus.icache_req_addr.tag      = it;
    bus.dcache_req_addr.valid    = dv;
    bus.dcache_req_addr.tag      = dt;
    bus.dcache_wb_valid          = wv;
    bus.dcache_wb_addr.valid     = wv;
    bus.dcache_wb_addr.tag       = wt;
    bus.dcache_wb_data           = wd;
    bus.mem2proc_transaction_tag = mt;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkAll(input string pfx, input logic [1:0] ecmd, input logic [31:0] eaddr,
                          input logic [63:0] edata, input logic eiacc, input logic edacc,
                          input logic eaf, input logic eovf);
    checkOutput({pfx, ".cmd"},  64'(bus.proc2mem_command), 64'(ecmd));
    checkOutput({pfx, ".addr"}, 64'(bus.proc2mem_addr), 64'(eaddr));
    checkOutput({pfx, ".data"}, bus.proc2mem_data, edata);
    checkOutput({pfx, ".iacc"}, 64'(bus.icache_req_accepted), 64'(eiacc));
    checkOutput({pfx, ".dacc"}, 64'(bus.dcache_req_accepted), 64'(edacc));
    checkOutput({pfx, ".af"},   64'(bus.wb_almost_full), 64'(eaf));
    checkOutput({pfx, ".ovf"},  64'(bus.wb_overflow), 64'(eovf));
    checkOutput({pfx, ".tag"},  64'(bus.current_req_tag), 64'(bus.mem2proc_transaction_tag));
  endtask

  task automatic addVec(input logic rst, input logic iv, input logic [12:0] it, input logic dv,
                        input logic [12:0] dt, input logic wv, input logic [12:0] wt,
                        input logic [63:0] wd, input logic [3:0] mt, input logic [1:0] ecmd,
                        input logic [31:0] eaddr, input logic [63:0] edata, input logic eiacc,
                        input logic edacc, input logic eaf, input logic eovf);
    vec_t v;
    v = '{rst, iv, it, dv, dt, wv, wt, wd, mt, ecmd, eaddr, edata, eiacc, edacc, eaf, eovf};
    vecs.push_back(v);
  endtask

  // True when a block tag is still owed to memory (queued or arriving now).
  function automatic bit mHaz(input logic [12:0] t);
    bit h;
    h = bus.dcache_wb_valid && (bus.dcache_wb_addr.tag == t);
    foreach (m_q[k]) if (m_q[k].tag == t) h = 1'b1;
    return h;
  endfunction

  task automatic modelEval();
    bit ih, dh, iok, dok;
    ih  = bus.icache_req_addr.valid && mHaz(bus.icache_req_addr.tag);
    dh  = bus.dcache_req_addr.valid && mHaz(bus.dcache_req_addr.tag);
    iok = bus.icache_req_addr.valid && !ih;
    dok = bus.dcache_req_addr.valid && !dh;
    if (reset) m_grant = 0;
    else if (m_q.size() > 0 && (m_q.size() >= WB_DEPTH - 1 || ih || dh)) m_grant = 1;
    else if (GUARD_EN && m_starve == STARVE_LIMIT && iok) m_grant = 2;
    else if (dok) m_grant = 3;
    else if (iok) m_grant = 2;
    else if (m_q.size() > 0) m_grant = 1;
    else m_grant = 0;
    e_cmd = MEM_NONE; e_addr = '0; e_data = '0;
    case (m_grant)
      1: begin e_cmd = MEM_STORE; e_addr = 32'(m_q[0].tag) * 8; e_data = m_q[0].data; end
      2: begin e_cmd = MEM_LOAD; e_addr = 32'(bus.icache_req_addr.tag) * 8; end
      3: begin e_cmd = MEM_LOAD; e_addr = 32'(bus.dcache_req_addr.tag) * 8; end
      default: ;
    endcase
    e_iacc = (m_grant == 2) && (bus.mem2proc_transaction_tag != 0);
    e_dacc = (m_grant == 3) && (bus.mem2proc_transaction_tag != 0);
    e_af   = !reset && (m_q.size() >= WB_DEPTH - 1);
    e_ovf  = !reset && m_ovf;
  endtask

  task automatic modelCommit();
    wb_entry_t e;
    if (reset) begin
      m_q.delete();
      m_starve = 0;
      m_ovf    = 1'b0;
      return;
    end
    if (m_grant == 1 && bus.mem2proc_transaction_tag != 0) void'(m_q.pop_front());
    if (bus.dcache_wb_valid) begin
      if (m_q.size() < WB_DEPTH) begin
        e.tag  = bus.dcache_wb_addr.tag;
        e.data = bus.dcache_wb_data;
        m_q.push_back(e);
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (bus.icache_req_addr.valid && !e_iacc)
      m_starve = (m_starve < STARVE_LIMIT) ? m_starve + 1 : STARVE_LIMIT;
    else
      m_starve = 0;
  endtask

  task automatic sampleCycle();
    @(negedge clock);
    modelEval();
  endtask

  task automatic finishCycle();
    @(posedge clock);
    modelCommit();
    #1;
  endtask

  task automatic idle(input logic [3:0] mt);
    applyStimulus(1'b0, 1'b0, 13'h0, 1'b0, 13'h0, 1'b0, 13'h0, 64'h0, mt);
  endtask

  task automatic resetCycle();
    applyStimulus(1'b1, 1'b0, 13'h0, 1'b0, 13'h0, 1'b0, 13'h0, 64'h0, 4'd0);
    sampleCycle();
    finishCycle();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Directed table, applied back to back from reset.
    addVec(1, 0, 13'h0,    1, 13'h1234, 0, 13'h0,  64'h0,    3, MEM_NONE,  32'h0,    64'h0,    0, 0, 0, 0);
    addVec(0, 0, 13'h0,    0, 13'h0,    0, 13'h0,  64'h0,    3, MEM_NONE,  32'h0,    64'h0,    0, 0, 0, 0);
    addVec(0, 0, 13'h0,    1, 13'h1234, 0, 13'h0,  64'h0,    3, MEM_LOAD,  32'h91A0, 64'h0,    0, 1, 0, 0);
    addVec(0, 1, 13'h30,   1, 13'h20,   1, 13'h10, 64'hAAAA, 5, MEM_LOAD,  32'h100,  64'h0,    0, 1, 0, 0);
    addVec(0, 1, 13'h30,   1, 13'h20,   0, 13'h0,  64'h0,    5, MEM_LOAD,  32'h100,  64'h0,    0, 1, 0, 0);
    addVec(0, 1, 13'h30,   1, 13'h20,   1, 13'h11, 64'hBBBB, 0, MEM_LOAD,  32'h100,  64'h0,    0, 0, 0, 0);
    addVec(0, 1, 13'h30,   1, 13'h20,   1, 13'h12, 64'hCCCC, 0, MEM_LOAD,  32'h100,  64'h0,    0, 0, 0, 0);
    addVec(0, 1, 13'h30,   1, 13'h20,   0, 13'h0,  64'h0,    7, MEM_STORE, 32'h80,   64'hAAAA, 0, 0, 1, 0);
    addVec(0, 1, 13'h30,   1, 13'h20,   0, 13'h0,  64'h0,    7, MEM_LOAD,  32'h100,  64'h0,    0, 1, 0, 0);
    addVec(0, 0, 13'h0,    0, 13'h0,    0, 13'h0,  64'h0,    7, MEM_STORE, 32'h88,   64'hBBBB, 0, 0, 0, 0);
    addVec(0, 0, 13'h0,    1, 13'h12,   0, 13'h0,  64'h0,    7, MEM_STORE, 32'h90,   64'hCCCC, 0, 0, 0, 0);
    addVec(0, 0, 13'h0,    1, 13'h12,   0, 13'h0,  64'h0,    7, MEM_LOAD,  32'h90,   64'h0,    0, 1, 0, 0);
    addVec(0, 0, 13'h0,    1, 13'h40,   1, 13'h40, 64'hDDDD, 7, MEM_NONE,  32'h0,    64'h0,    0, 0, 0, 0);
    addVec(0, 0, 13'h0,    1, 13'h40,   0, 13'h0,  64'h0,    7, MEM_STORE, 32'h200,  64'hDDDD, 0, 0, 0, 0);
    addVec(0, 0, 13'h0,    1, 13'h40,   0, 13'h0,  64'h0,    7, MEM_LOAD,  32'h200,  64'h0,    0, 1, 0, 0);
    addVec(0, 0, 13'h0,    0, 13'h0,    1, 13'h50, 64'hEEEE, 7, MEM_NONE,  32'h0,    64'h0,    0, 0, 0, 0);
    addVec(0, 1, 13'h50,   0, 13'h0,    0, 13'h0,  64'h0,    7, MEM_STORE, 32'h280,  64'hEEEE, 0, 0, 0, 0);
    addVec(0, 1, 13'h50,   0, 13'h0,    0, 13'h0,  64'h0,    7, MEM_LOAD,  32'h280,  64'h0,    1, 0, 0, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].iv, vecs[i].it, vecs[i].dv, vecs[i].dt,
                    vecs[i].wv, vecs[i].wt, vecs[i].wd, vecs[i].mt);
      sampleCycle();
      checkAll($sformatf("vec%0d", i), vecs[i].e_cmd, vecs[i].e_addr, vecs[i].e_data,
               vecs[i].e_iacc, vecs[i].e_dacc, vecs[i].e_af, vecs[i].e_ovf);
      finishCycle();
    end

    // Retry: a zero memory tag keeps the store at the head without popping.
    resetCycle();
    applyStimulus(1'b0, 1'b0, 13'h0, 1'b0, 13'h0, 1'b1, 13'h70, 64'h7777, 4'd0);
    sampleCycle();
    checkOutput("retry.push_cmd", 64'(bus.proc2mem_command), 64'(MEM_NONE));
    finishCycle();
    for (int c = 1; c <= 3; c++) begin
      idle((c == 3) ? 4'd9 : 4'd0);
      sampleCycle();
      checkOutput($sformatf("retry%0d.cmd", c), 64'(bus.proc2mem_command), 64'(MEM_STORE));
      checkOutput($sformatf("retry%0d.addr", c), 64'(bus.proc2mem_addr), 64'h380);
      checkOutput($sformatf("retry%0d.data", c), bus.proc2mem_data, 64'h7777);
      finishCycle();
    end
    idle(4'd9);
    sampleCycle();
    checkOutput("retry.after_pop_cmd", 64'(bus.proc2mem_command), 64'(MEM_NONE));
    finishCycle();

    // Starvation: dcache asks every cycle, icache waits.
    resetCycle();
    for (int c = 1; c <= 12; c++) begin
      bit win;
      win = GUARD_EN && (c == 9);
      applyStimulus(1'b0, 1'b1, 13'h101, 1'b1, 13'h100, 1'b0, 13'h0, 64'h0, 4'd1);
      sampleCycle();
      checkOutput($sformatf("starve%0d.iacc", c), 64'(bus.icache_req_accepted), 64'(win));
      checkOutput($sformatf("starve%0d.dacc", c), 64'(bus.dcache_req_accepted), 64'(!win));
      checkOutput($sformatf("starve%0d.addr", c), 64'(bus.proc2mem_addr), win ? 64'h808 : 64'h800);
      finishCycle();
    end

    // Overflow: five pushes with memory refusing every request.
    resetCycle();
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1'b0, 1'b0, 13'h0, 1'b0, 13'h0, 1'b1, 13'(k), 64'(k), 4'd0);
      sampleCycle();
      checkOutput($sformatf("ovf_push%0d.af", k), 64'(bus.wb_almost_full), 64'(k >= 4));
      checkOutput($sformatf("ovf_push%0d.ovf", k), 64'(bus.wb_overflow), 64'h0);
      finishCycle();
    end
    idle(4'd0);
    sampleCycle();
    checkAll("ovf_after", MEM_STORE, 32'h8, 64'h1, 1'b0, 1'b0, 1'b1, 1'b1);
    finishCycle();
    applyStimulus(1'b1, 1'b1, 13'h5, 1'b1, 13'h6, 1'b1, 13'h7, 64'h9, 4'd5);
    sampleCycle();
    checkAll("ovf_in_reset", MEM_NONE, 32'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    finishCycle();
    idle(4'd5);
    sampleCycle();
    checkAll("ovf_cleared", MEM_NONE, 32'h0, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    finishCycle();

    // Full FIFO: a push in the same cycle as a pop is accepted without overflow.
    resetCycle();
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b0, 1'b0, 13'h0, 1'b0, 13'h0, 1'b1, 13'(32 + k), 64'(32 + k), 4'd0);
      sampleCycle();
      finishCycle();
    end
    applyStimulus(1'b0, 1'b0, 13'h0, 1'b0, 13'h0, 1'b1, 13'h25, 64'h25, 4'd5);
    sampleCycle();
    checkOutput("full_pp.addr", 64'(bus.proc2mem_addr), 64'h108);
    finishCycle();
    idle(4'd0);
    sampleCycle();
    checkOutput("full_pp.af", 64'(bus.wb_almost_full), 64'h1);
    checkOutput("full_pp.ovf", 64'(bus.wb_overflow), 64'h0);
    finishCycle();
    for (int k = 2; k <= 6; k++) begin
      idle(4'd5);
      sampleCycle();
      if (k <= 5) begin
        checkOutput($sformatf("drain%0d.addr", k), 64'(bus.proc2mem_addr), 64'(32 + k) * 8);
        checkOutput($sformatf("drain%0d.data", k), bus.proc2mem_data, 64'(32 + k));
      end else begin
        checkOutput("drain_end.cmd", 64'(bus.proc2mem_command), 64'(MEM_NONE));
      end
      finishCycle();
    end

    // Randomized traffic against the reference model.
    resetCycle();
    for (int n = 0; n < 600; n++) begin
      applyStimulus(($urandom % 150) == 0,
                    1'($urandom % 2), 13'($urandom_range(0, 7)),
                    1'($urandom % 2), 13'($urandom_range(0, 7)),
                    ($urandom % 3) == 0, 13'($urandom_range(0, 7)),
                    {$urandom, $urandom},
                    (($urandom % 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15)));
      sampleCycle();
      checkAll($sformatf("rand%0d", n), e_cmd, e_addr, e_data, e_iacc, e_dacc, e_af, e_ovf);
      finishCycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
